// File: rtl/lzc_pkg.sv
// Shared types and width helper for the pipelined leading/trailing zero/one counter.
package lzc_pkg;
  typedef enum logic [1:0] {CLZ = 2'b00, CTZ = 2'b01, CLO = 2'b10, CTO = 2'b11} lzc_mode_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/lzc_pipe_if.sv
// Operand/result handshake bundle for lzc_pipe.
interface lzc_pipe_if
  import lzc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
);
  localparam int CW = cnt_w(WIDTH);

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InNum;
  lzc_mode_t        InMode;
  logic [TAGW-1:0]  InTag;
  logic             OutValid;
  logic             OutReady;
  logic [CW-1:0]    OutCnt;
  logic             OutAll;
  logic [TAGW-1:0]  OutTag;

  modport master (output InValid, InNum, InMode, InTag, OutReady,
                  input  InReady, OutValid, OutCnt, OutAll, OutTag);
  modport slave  (input  InValid, InNum, InMode, InTag, OutReady,
                  output InReady, OutValid, OutCnt, OutAll, OutTag);
endinterface

// File: rtl/lzc_tree.sv
// Combinational recursive leading-zero counter; splits the operand in halves down to single bits.
module lzc_tree
  import lzc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]        num,
  output logic [cnt_w(WIDTH)-1:0] cnt,
  output logic                    zero
);
  if (WIDTH == 1) begin : g_leaf
    assign cnt  = ~num;
    assign zero = ~num[0];
  end else begin : g_node
    localparam int CW = cnt_w(WIDTH);
    localparam int WH = (WIDTH + 1) / 2;
    localparam int WL = WIDTH - WH;

    logic [cnt_w(WH)-1:0] cnt_h;
    logic [cnt_w(WL)-1:0] cnt_l;
    logic                 z_h, z_l;

    lzc_tree #(.WIDTH(WH)) u_hi (.num(num[WIDTH-1 -: WH]), .cnt(cnt_h), .zero(z_h));
    lzc_tree #(.WIDTH(WL)) u_lo (.num(num[WL-1:0]),        .cnt(cnt_l), .zero(z_l));

    assign zero = z_h & z_l;
    assign cnt  = z_h ? CW'(WH) + CW'(cnt_l) : CW'(cnt_h);
  end
endmodule

// File: rtl/lzc_pipe.sv
// Pipelined CLZ/CTZ/CLO/CTO unit with valid/ready back-pressure and a side-band tag.
// Modes are folded into a plain CLZ by inverting/reversing before the first register.
module lzc_pipe
  import lzc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CHUNK  = 8,
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic     clk,
  input  logic     reset,
  lzc_pipe_if.slave io
);
  localparam int CW = cnt_w(WIDTH);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("lzc_pipe: WIDTH must be a multiple of CHUNK");
  end
  if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
    $error("lzc_pipe: STAGES must be 1 or 2");
  end

  logic [WIDTH-1:0] inv, opd;
  always_comb begin
    inv = io.InMode[1] ? ~io.InNum : io.InNum;
    opd = inv;
    if (io.InMode[0])
      for (int b = 0; b < WIDTH; b++) opd[b] = inv[WIDTH-1-b];
  end

  // rdy[i] is the load enable of stage i; rdy[STAGES+1] is the consumer.
  logic [STAGES:1]   vld_pipe;
  logic [STAGES:0]   vld_shift;
  logic [STAGES+1:1] rdy;
  assign vld_shift = {vld_pipe, io.InValid};

  always_comb begin
    rdy = '0;
    rdy[STAGES+1] = io.OutReady;
    for (int i = STAGES; i >= 1; i--) rdy[i] = ~vld_pipe[i] | rdy[i+1];
  end

  assign io.InReady = rdy[1] & ~reset;

  logic [CW-1:0]   cnt_d, out_cnt;
  logic            all_d, out_all;
  logic [TAGW-1:0] tag_d, out_tag;

  if (STAGES == 1) begin : g_s1
    lzc_tree #(.WIDTH(WIDTH)) u_tree (.num(opd), .cnt(cnt_d), .zero(all_d));
    assign tag_d = io.InTag;
  end else begin : g_s2
    localparam int NCH = WIDTH / CHUNK;
    localparam int CCW = cnt_w(CHUNK);

    logic [NCH-1:0][CCW-1:0] ch_cnt_d, ch_cnt_q;
    logic [NCH-1:0]          ch_z_d, ch_z_q;
    logic [TAGW-1:0]         tag_q;

    // Chunk k = 0 is the most significant segment.
    for (genvar k = 0; k < NCH; k++) begin : g_chunk
      lzc_tree #(.WIDTH(CHUNK)) u_tree (
        .num (opd[WIDTH-1-k*CHUNK -: CHUNK]),
        .cnt (ch_cnt_d[k]),
        .zero(ch_z_d[k])
      );
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        ch_cnt_q <= '0;
        ch_z_q   <= '0;
        tag_q    <= '0;
      end else if (rdy[1] && io.InValid) begin
        ch_cnt_q <= ch_cnt_d;
        ch_z_q   <= ch_z_d;
        tag_q    <= io.InTag;
      end
    end

    logic found;
    always_comb begin
      cnt_d = '0;
      found = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        if (!found) begin
          if (ch_z_q[k]) cnt_d = cnt_d + CW'(CHUNK);
          else begin
            cnt_d = cnt_d + CW'(ch_cnt_q[k]);
            found = 1'b1;
          end
        end
      end
    end

    assign all_d = &ch_z_q;
    assign tag_d = tag_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      out_cnt  <= '0;
      out_all  <= 1'b0;
      out_tag  <= '0;
    end else begin
      for (int i = 1; i <= STAGES; i++)
        if (rdy[i]) vld_pipe[i] <= vld_shift[i-1];
      if (rdy[STAGES] && vld_shift[STAGES-1]) begin
        out_cnt <= cnt_d;
        out_all <= all_d;
        out_tag <= tag_d;
      end
    end
  end

  assign io.OutValid = vld_pipe[STAGES];
  assign io.OutCnt   = out_cnt;
  assign io.OutAll   = out_all;
  assign io.OutTag   = out_tag;
endmodule

// File: tb/tb_lzc_pipe.sv
// Self-checking bench for lzc_pipe (WIDTH=32, CHUNK=8, STAGES=2) against a bit-scan reference model.
module tb_lzc_pipe;
  import lzc_pkg::*;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int STAGES = 2;
  localparam int TAGW   = 4;
  localparam int CW     = 6;
  localparam int NRAND  = 10000;

  typedef struct {
    int              cnt;
    logic [TAGW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lzc_pipe_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();

  lzc_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Scan from the counted end until the first bit that breaks the run.
  function automatic int ref_count(input logic [WIDTH-1:0] v, input lzc_mode_t m);
    int  n     = 0;
    bit  ones  = (m == CLO) || (m == CTO);
    bit  trail = (m == CTZ) || (m == CTO);
    bit  run   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      int b;
      b = trail ? i : WIDTH - 1 - i;
      if (run && (v[b] == ones)) n++;
      else run = 1'b0;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.InValid  = 1'b0;
    bus.InNum    = '0;
    bus.InMode   = CLZ;
    bus.InTag    = '0;
    bus.OutReady = 1'b1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.InValid  = 1'b1;
    bus.InNum    = 32'h0000_00FF;
    bus.InMode   = CLZ;
    bus.InTag    = 4'h5;
    bus.OutReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      n_chk += 3;
      if (bus.OutValid !== 1'b0) begin
        n_fail++; $display("FAIL reset_outvalid cyc=%0d got=%b want=0", c, bus.OutValid);
      end
      if (bus.OutCnt !== 6'd0) begin
        n_fail++; $display("FAIL reset_outcnt cyc=%0d got=%0d want=0", c, bus.OutCnt);
      end
      if (bus.InReady !== 1'b0) begin
        n_fail++; $display("FAIL reset_inready cyc=%0d got=%b want=0", c, bus.InReady);
      end
    end
    tick();
    reset = 1'b0;
    idle();
    @(negedge clk);
    n_chk += 2;
    if (bus.InReady !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_inready got=%b want=1", bus.InReady);
    end
    if (bus.OutValid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_outvalid got=%b want=0", bus.OutValid);
    end
    tick();
  endtask

  task automatic test_modes();
    lzc_mode_t       mt[6] = '{CLZ, CLZ, CLZ, CTZ, CLO, CTO};
    logic [31:0]     nt[6] = '{32'h0001_0000, 32'h0000_0000, 32'h8000_0000,
                               32'h0001_0000, 32'hFF00_0000, 32'hFFFF_FFFF};
    int              et[6] = '{15, 32, 0, 16, 8, 32};
    for (int i = 0; i < 6; i++) begin
      bus.InValid  = 1'b1;
      bus.InNum    = nt[i];
      bus.InMode   = mt[i];
      bus.InTag    = TAGW'(i + 3);
      bus.OutReady = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus.InReady !== 1'b1) begin
        n_fail++; $display("FAIL mode%0d_inready got=%b want=1", i, bus.InReady);
      end
      tick();
      bus.InValid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (bus.OutValid !== 1'b0) begin
        n_fail++; $display("FAIL mode%0d_early_valid got=%b want=0", i, bus.OutValid);
      end
      tick();
      @(negedge clk);
      n_chk += 4;
      if (bus.OutValid !== 1'b1) begin
        n_fail++; $display("FAIL mode%0d_valid got=%b want=1", i, bus.OutValid);
      end
      if (bus.OutCnt !== CW'(et[i])) begin
        n_fail++; $display("FAIL mode%0d_cnt got=%0d want=%0d", i, bus.OutCnt, et[i]);
      end
      if (bus.OutAll !== (et[i] == WIDTH)) begin
        n_fail++; $display("FAIL mode%0d_all got=%b want=%b", i, bus.OutAll, et[i] == WIDTH);
      end
      if (bus.OutTag !== TAGW'(i + 3)) begin
        n_fail++; $display("FAIL mode%0d_tag got=%0d want=%0d", i, bus.OutTag, i + 3);
      end
      tick();
    end
  endtask

  task automatic test_stream();
    logic [31:0] nt[4] = '{32'h1, 32'h10, 32'h100, 32'h1000};
    int          et[4] = '{31, 27, 23, 19};
    for (int c = 0; c < 8; c++) begin
      bus.OutReady = 1'b1;
      if (c < 4) begin
        bus.InValid = 1'b1;
        bus.InNum   = nt[c];
        bus.InMode  = CLZ;
        bus.InTag   = TAGW'(c + 1);
      end else begin
        bus.InValid = 1'b0;
      end
      @(negedge clk);
      if (c < 4) begin
        n_chk++;
        if (bus.InReady !== 1'b1) begin
          n_fail++; $display("FAIL stream_inready cyc=%0d got=%b want=1", c, bus.InReady);
        end
      end
      n_chk++;
      if (c >= 2 && c <= 5) begin
        if (bus.OutValid !== 1'b1 || bus.OutCnt !== CW'(et[c-2]) || bus.OutTag !== TAGW'(c - 1)) begin
          n_fail++;
          $display("FAIL stream_out cyc=%0d got v=%b cnt=%0d tag=%0d want v=1 cnt=%0d tag=%0d",
                   c, bus.OutValid, bus.OutCnt, bus.OutTag, et[c-2], c - 1);
        end
      end else if (bus.OutValid !== 1'b0) begin
        n_fail++; $display("FAIL stream_idle cyc=%0d got v=%b want v=0", c, bus.OutValid);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]     nt[6] = '{32'h0000_0003, 32'h0004_0000, 32'h0000_0000,
                               32'h0F00_0000, 32'h0000_8000, 32'h8000_0001};
    exp_t            q[$];
    exp_t            e;
    int              idx = 0, accepts = 0, recv = 0;
    bit              held = 1'b0;
    logic [CW-1:0]   hold_cnt = '0;
    logic [TAGW-1:0] hold_tag = '0;
    bus.OutReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.InValid = 1'b1;
      bus.InNum   = nt[idx];
      bus.InMode  = CLZ;
      bus.InTag   = TAGW'(idx + 8);
      @(negedge clk);
      if (bus.OutValid) begin
        if (held) begin
          n_chk++;
          if (bus.OutCnt !== hold_cnt || bus.OutTag !== hold_tag) begin
            n_fail++;
            $display("FAIL bp_stable cyc=%0d got cnt=%0d tag=%0d want cnt=%0d tag=%0d",
                     c, bus.OutCnt, bus.OutTag, hold_cnt, hold_tag);
          end
        end
        held     = 1'b1;
        hold_cnt = bus.OutCnt;
        hold_tag = bus.OutTag;
      end
      if (bus.InValid && bus.InReady) begin
        q.push_back('{ref_count(nt[idx], CLZ), TAGW'(idx + 8)});
        idx++;
        accepts++;
      end
      tick();
    end
    @(negedge clk);
    n_chk += 2;
    if (accepts != 2) begin
      n_fail++; $display("FAIL bp_accepts got=%0d want=2", accepts);
    end
    if (bus.InReady !== 1'b0) begin
      n_fail++; $display("FAIL bp_inready_full got=%b want=0", bus.InReady);
    end
    tick();
    bus.OutReady = 1'b1;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      bus.InValid = (idx < 6);
      if (idx < 6) begin
        bus.InNum = nt[idx];
        bus.InTag = TAGW'(idx + 8);
      end
      @(negedge clk);
      if (bus.OutValid && bus.OutReady) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra got cnt=%0d tag=%0d want none", bus.OutCnt, bus.OutTag);
        end else begin
          e = q.pop_front();
          if (bus.OutCnt !== CW'(e.cnt) || bus.OutTag !== e.tag) begin
            n_fail++;
            $display("FAIL bp_drain got cnt=%0d tag=%0d want cnt=%0d tag=%0d",
                     bus.OutCnt, bus.OutTag, e.cnt, e.tag);
          end
        end
        recv++;
      end
      if (bus.InValid && bus.InReady) begin
        q.push_back('{ref_count(nt[idx], CLZ), TAGW'(idx + 8)});
        idx++;
      end
      tick();
    end
    bus.InValid = 1'b0;
    n_chk++;
    if (recv != 6 || q.size() != 0) begin
      n_fail++; $display("FAIL bp_total got recv=%0d left=%0d want recv=6 left=0", recv, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    idle();
    bus.OutReady = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.InValid = 1'b1;
      bus.InNum   = 32'h0000_0100 << c;
      bus.InTag   = TAGW'(c + 1);
      tick();
    end
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (bus.OutValid !== 1'b0) begin
        n_fail++; $display("FAIL midreset_outvalid cyc=%0d got=%b want=0", c, bus.OutValid);
      end
      tick();
    end
  endtask

  task automatic test_random();
    exp_t            q[$];
    exp_t            e;
    int              sent = 0, recv = 0, cyc = 0;
    bit              offering = 1'b0;
    bit              prev_stall = 1'b0;
    logic [CW-1:0]   prev_cnt = '0;
    logic [TAGW-1:0] prev_tag = '0;
    logic [31:0]     v;
    idle();
    while (recv < NRAND && cyc < 60000) begin
      if (!offering && sent < NRAND && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0:       v = 32'h0;
          1:       v = 32'hFFFF_FFFF;
          2:       v = 32'h1 << $urandom_range(0, 31);
          3:       v = ~(32'h1 << $urandom_range(0, 31));
          default: v = $urandom >> $urandom_range(0, 31);
        endcase
        bus.InNum   = v;
        bus.InMode  = lzc_mode_t'($urandom_range(0, 3));
        bus.InTag   = TAGW'($urandom);
        bus.InValid = 1'b1;
        offering    = 1'b1;
      end
      bus.OutReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall) begin
        n_chk++;
        if (bus.OutValid !== 1'b1 || bus.OutCnt !== prev_cnt || bus.OutTag !== prev_tag) begin
          n_fail++;
          $display("FAIL rnd_hold got v=%b cnt=%0d tag=%0d want v=1 cnt=%0d tag=%0d",
                   bus.OutValid, bus.OutCnt, bus.OutTag, prev_cnt, prev_tag);
        end
      end
      if (bus.OutValid && bus.OutReady) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra got cnt=%0d tag=%0d want none", bus.OutCnt, bus.OutTag);
        end else begin
          e = q.pop_front();
          if (bus.OutCnt !== CW'(e.cnt) || bus.OutAll !== (e.cnt == WIDTH) || bus.OutTag !== e.tag) begin
            n_fail++;
            $display("FAIL rnd_result #%0d got cnt=%0d all=%b tag=%0d want cnt=%0d all=%b tag=%0d",
                     recv, bus.OutCnt, bus.OutAll, bus.OutTag, e.cnt, e.cnt == WIDTH, e.tag);
          end
        end
        recv++;
      end
      if (bus.InValid && bus.InReady) begin
        q.push_back('{ref_count(bus.InNum, bus.InMode), bus.InTag});
        sent++;
        offering = 1'b0;
      end
      prev_stall = bus.OutValid && !bus.OutReady;
      prev_cnt   = bus.OutCnt;
      prev_tag   = bus.OutTag;
      tick();
      if (!offering) bus.InValid = 1'b0;
      cyc++;
    end
    n_chk++;
    if (recv != NRAND || q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_total got recv=%0d left=%0d cyc=%0d want recv=%0d left=0", recv, q.size(), cyc, NRAND);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_modes();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
